// File: rtl/pwm_pattern_pkg.sv
// Shared types for the N-channel pattern PWM engine.
// Optional build macro: PWM_POLARITY_EN (per-channel output polarity).
package pwm_pattern_pkg;

  // Command encodings carried on cfg_cmd alongside the cfg_wr strobe.
  typedef enum logic [1:0] {
    CMD_LOAD    = 2'b00,
    CMD_START   = 2'b01,
    CMD_STOP    = 2'b10,
    CMD_RESTART = 2'b11
  } cfg_cmd_e;

  // Per-channel sequencer state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BIT  = 2'b01,
    ST_GAP  = 2'b10,
    ST_DONE = 2'b11
  } ch_state_e;

  // Field widths of the default build, matching the UART decoder fields.
  localparam int DEF_DUTY_W    = 8;
  localparam int DEF_GAP_W     = 16;
  localparam int DEF_REP_W     = 8;
  localparam int DEF_PAT_WIDTH = 16;

  // Channel configuration record as delivered by the command path.
  typedef struct packed {
    logic [DEF_DUTY_W-1:0]    duty;
    logic [DEF_GAP_W-1:0]     gap;
    logic [DEF_REP_W-1:0]     rep;
    logic [DEF_PAT_WIDTH-1:0] pat;
  } ch_cfg_t;

  // A channel counts as running while it is emitting bits or gap cycles.
  function automatic logic state_is_busy(ch_state_e s);
    return (s == ST_BIT) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/pwm_pattern_ch.sv
// One pattern-PWM channel: shadow/active configuration, sequencer FSM,
// bit/duty/gap/repetition counters and the registered output bit.
// Polarity inputs are tied off by the top unless PWM_POLARITY_EN is defined.
module pwm_pattern_ch
  import pwm_pattern_pkg::*;
#(
  parameter int PAT_WIDTH = 16,
  parameter int DUTY_W    = 8,
  parameter int GAP_W     = 16,
  parameter int REP_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 restart,
  input  logic [DUTY_W-1:0]    cfg_duty,
  input  logic [GAP_W-1:0]     cfg_gap,
  input  logic [REP_W-1:0]     cfg_rep,
  input  logic [PAT_WIDTH-1:0] cfg_pat,
  input  logic                 pol_wr,
  input  logic                 pol_in,
  output logic                 pwm_out,
  output ch_state_e            state
);

  localparam int BW = (PAT_WIDTH > 1) ? $clog2(PAT_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(PAT_WIDTH - 1);

  typedef struct packed {
    logic [DUTY_W-1:0]    duty;
    logic [GAP_W-1:0]     gap;
    logic [REP_W-1:0]     rep;
    logic [PAT_WIDTH-1:0] pat;
  } cfg_t;

  ch_state_e         state_q, state_n;
  cfg_t              shadow_q, shadow_n;
  cfg_t              active_q, active_n;
  cfg_t              cfg_in;
  logic [BW-1:0]     bit_idx_q, bit_idx_n;
  logic [DUTY_W-1:0] duty_cnt_q, duty_cnt_n;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_n;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_n;
  logic [REP_W-1:0]  rep_inc;
  logic [DUTY_W-1:0] duty_last;
  logic [GAP_W-1:0]  gap_last;
  logic              eop;
  logic              running;
  logic              raw_q, raw_n;
  logic              pol_q;

  assign state   = state_q;
  assign pwm_out = raw_q ^ pol_q;

  // Next-state logic: sequencing first, then commands override it.
  always_comb begin
    cfg_in.duty = cfg_duty;
    cfg_in.gap  = cfg_gap;
    cfg_in.rep  = cfg_rep;
    cfg_in.pat  = cfg_pat;

    // A load lands in the shadow set; a coincident boundary already sees it.
    shadow_n   = load ? cfg_in : shadow_q;
    active_n   = active_q;
    state_n    = state_q;
    bit_idx_n  = bit_idx_q;
    duty_cnt_n = duty_cnt_q;
    gap_cnt_n  = gap_cnt_q;
    rep_cnt_n  = rep_cnt_q;
    eop        = 1'b0;
    running    = state_is_busy(state_q);

    // duty=0 behaves as one cycle per bit; gap_last only matters when gap!=0.
    duty_last = (active_q.duty == '0) ? '0 : active_q.duty - 1'b1;
    gap_last  = active_q.gap - 1'b1;
    rep_inc   = (rep_cnt_q == '1) ? rep_cnt_q : rep_cnt_q + 1'b1;

    case (state_q)
      ST_BIT: begin
        if (duty_cnt_q >= duty_last) begin
          duty_cnt_n = '0;
          if (bit_idx_q == LAST_BIT) begin
            if (active_q.gap != '0) begin
              state_n   = ST_GAP;
              gap_cnt_n = '0;
            end else begin
              eop = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx_q + 1'b1;
          end
        end else begin
          duty_cnt_n = duty_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q >= gap_last) begin
          eop = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // End of one pattern repetition: finish, or pick up the shadow set.
    if (eop) begin
      rep_cnt_n = rep_inc;
      if ((active_q.rep != '0) && (rep_inc == active_q.rep)) begin
        state_n = ST_DONE;
      end else begin
        active_n   = shadow_n;
        state_n    = ST_BIT;
        bit_idx_n  = '0;
        duty_cnt_n = '0;
        gap_cnt_n  = '0;
      end
    end

    // Stop wins over everything; start only acts on a non-running channel.
    if (stop) begin
      state_n    = ST_IDLE;
      bit_idx_n  = '0;
      duty_cnt_n = '0;
      gap_cnt_n  = '0;
      rep_cnt_n  = '0;
    end else if (restart || (start && !running)) begin
      active_n   = cfg_in;
      state_n    = ST_BIT;
      bit_idx_n  = '0;
      duty_cnt_n = '0;
      gap_cnt_n  = '0;
      rep_cnt_n  = '0;
    end

    raw_n = (state_n == ST_BIT) ? active_n.pat[bit_idx_n] : 1'b0;
  end

  // State, configuration and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      active_q   <= '0;
      bit_idx_q  <= '0;
      duty_cnt_q <= '0;
      gap_cnt_q  <= '0;
      rep_cnt_q  <= '0;
      raw_q      <= 1'b0;
      pol_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      shadow_q   <= shadow_n;
      active_q   <= active_n;
      bit_idx_q  <= bit_idx_n;
      duty_cnt_q <= duty_cnt_n;
      gap_cnt_q  <= gap_cnt_n;
      rep_cnt_q  <= rep_cnt_n;
      raw_q      <= raw_n;
      if (pol_wr) begin
        pol_q <= pol_in;
      end
    end
  end

endmodule

// File: rtl/pwm_pattern_array.sv
// N-channel pattern PWM engine. Decodes the channel mask and command into
// per-channel strobes and replicates pwm_pattern_ch once per channel.
// Optional build macro: PWM_POLARITY_EN adds cfg_pol and per-channel polarity.
//
// Interface timing: cfg_wr is a one-cycle strobe with no back-pressure; the
// command is always accepted in the cycle it is presented. valid is a
// one-cycle completion pulse per channel with no ready; it coincides with
// busy falling and never occurs for infinite-repetition runs or stops.
module pwm_pattern_array
  import pwm_pattern_pkg::*;
#(
  parameter int _CH_NUM    = 8,
  parameter int _PAT_WIDTH = 16,
  parameter int _DUTY_W    = 8,
  parameter int _GAP_W     = 16,
  parameter int _REP_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [_CH_NUM-1:0]    cfg_ch_mask,
  input  logic [1:0]            cfg_cmd,
  input  logic [_DUTY_W-1:0]    cfg_duty,
  input  logic [_GAP_W-1:0]     cfg_gap,
  input  logic [_REP_W-1:0]     cfg_rep,
  input  logic [_PAT_WIDTH-1:0] cfg_pat,
`ifdef PWM_POLARITY_EN
  input  logic [_CH_NUM-1:0]    cfg_pol,
`endif
  output logic [_CH_NUM-1:0]    pwm_out,
  output logic [_CH_NUM-1:0]    busy,
  output logic [_CH_NUM-1:0]    valid
);

  cfg_cmd_e  cmd;
  ch_state_e ch_state [_CH_NUM];

  assign cmd = cfg_cmd_e'(cfg_cmd);

  for (genvar i = 0; i < _CH_NUM; i++) begin : g_ch
    logic sel;
    logic load_s;
    logic start_s;
    logic stop_s;
    logic restart_s;
    logic pol_wr;
    logic pol_in;

    assign sel       = cfg_wr & cfg_ch_mask[i];
    assign load_s    = sel & (cmd != CMD_STOP);
    assign start_s   = sel & (cmd == CMD_START);
    assign stop_s    = sel & (cmd == CMD_STOP);
    assign restart_s = sel & (cmd == CMD_RESTART);

`ifdef PWM_POLARITY_EN
    assign pol_wr = load_s;
    assign pol_in = cfg_pol[i];
`else
    assign pol_wr = 1'b0;
    assign pol_in = 1'b0;
`endif

    pwm_pattern_ch #(
      .PAT_WIDTH (_PAT_WIDTH),
      .DUTY_W    (_DUTY_W),
      .GAP_W     (_GAP_W),
      .REP_W     (_REP_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .load     (load_s),
      .start    (start_s),
      .stop     (stop_s),
      .restart  (restart_s),
      .cfg_duty (cfg_duty),
      .cfg_gap  (cfg_gap),
      .cfg_rep  (cfg_rep),
      .cfg_pat  (cfg_pat),
      .pol_wr   (pol_wr),
      .pol_in   (pol_in),
      .pwm_out  (pwm_out[i]),
      .state    (ch_state[i])
    );

    assign busy[i]  = state_is_busy(ch_state[i]);
    assign valid[i] = (ch_state[i] == ST_DONE);
  end

endmodule
